// File: rtl/a2d_sched_if.sv
// a2d_sched_if
//   Request/result bundle between the conversion scheduler and the 3-channel
//   A2D interface (left load cell, battery, right load cell).
//
//   nxt       scheduler -> A2D  one-cycle conversion request
//   cnv_done  A2D -> scheduler  one-cycle completion pulse
//   lft_ld    A2D -> scheduler  12-bit left load cell result register
//   batt      A2D -> scheduler  12-bit battery result register
//   rght_ld   A2D -> scheduler  12-bit right load cell result register
//
//   master : scheduler side
//   slave  : A2D interface side
interface a2d_sched_if;
  logic        nxt;
  logic        cnv_done;
  logic [11:0] lft_ld;
  logic [11:0] batt;
  logic [11:0] rght_ld;

  modport master (
    output nxt,
    input  cnv_done,
    input  lft_ld,
    input  batt,
    input  rght_ld
  );

  modport slave (
    input  nxt,
    output cnv_done,
    output lft_ld,
    output batt,
    output rght_ld
  );
endinterface

// File: rtl/a2d_sched.sv
// a2d_sched
//   Issues periodic one-cycle conversion requests to the A2D interface,
//   follows its left -> batt -> right round robin, accumulates 2^AVG_LOG2
//   full rounds per channel and publishes truncated averages with a strobe.
//   A watchdog parks the scheduler in HALT if a conversion never completes.
//
//   Parameters: PERIOD   minimum cycles between nxt pulses (>= 8)
//               TMO      max cycles from nxt to cnv_done
//               AVG_LOG2 log2 of rounds averaged (0..4)
//   Ports:      clk, rst_n (async, active-low)
//               en       scheduling enable (level)
//               clr_err  clears tmo_err and leaves HALT
//               a2d      request/result bundle (master side)
//               lft_avg, batt_avg, rght_avg  averaged results
//               avg_vld  one-cycle pulse when averages update
//               ch       channel of the outstanding or next conversion
//               tmo_err  sticky timeout flag
module a2d_sched #(
  parameter int PERIOD   = 4096,
  parameter int TMO      = 1024,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_err,
  a2d_sched_if.master      a2d,
  output logic [11:0]      lft_avg,
  output logic [11:0]      batt_avg,
  output logic [11:0]      rght_avg,
  output logic             avg_vld,
  output logic [1:0]       ch,
  output logic             tmo_err
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int RND_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [RND_W-1:0] RND_LAST = RND_W'((1 << AVG_LOG2) - 1);
  localparam logic [15:0] PER_LAST = 16'(PERIOD - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    REQ  = 3'd2,
    BUSY = 3'd3,
    CAPT = 3'd4,
    HALT = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      timer_reg, timer_next;
  logic [15:0]      wd_reg, wd_next;
  logic [1:0]       ch_reg;
  logic [RND_W-1:0] round_reg;
  logic             avg_vld_reg;
  logic             tmo_err_reg;

  logic             timeout;
  logic             capt;
  logic             round_last;
  logic             publish;
  logic             acc_clr;
  logic [11:0]      sample;

  // cnv_done has priority over an expiring watchdog in the same cycle.
  assign timeout    = (state_reg == BUSY) && !a2d.cnv_done && (wd_reg >= TMO_LAST);
  assign capt       = (state_reg == CAPT);
  assign round_last = (round_reg == RND_LAST);
  assign publish    = capt && (ch_reg == 2'd2) && round_last;
  assign acc_clr    = publish || timeout;

  always_comb begin
    sample = '0;
    case (ch_reg)
      2'd0:    sample = a2d.lft_ld;
      2'd1:    sample = a2d.batt;
      2'd2:    sample = a2d.rght_ld;
      default: sample = '0;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (en) state_next = WAIT;
      WAIT: begin
        if (!en)                       state_next = IDLE;
        else if (timer_reg >= PER_LAST) state_next = REQ;
      end
      REQ:  state_next = BUSY;
      BUSY: begin
        if (a2d.cnv_done) state_next = CAPT;
        else if (timeout) state_next = HALT;
      end
      CAPT: state_next = WAIT;
      HALT: if (clr_err) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    a2d.nxt = (state_reg == REQ);
  end

  // Period timer. The REQ cycle itself is tick 0, so the following cycle
  // reads 1 and nxt-to-nxt spacing comes out at exactly PERIOD.
  always_comb begin
    timer_next = timer_reg;
    case (state_reg)
      IDLE:    timer_next = '0;
      REQ:     timer_next = 16'd1;
      HALT:    timer_next = timer_reg;
      default: if (timer_reg != 16'hFFFF) timer_next = timer_reg + 16'd1;
    endcase
  end

  always_comb begin
    wd_next = wd_reg;
    case (state_reg)
      REQ:     wd_next = '0;
      BUSY:    if (wd_reg != 16'hFFFF) wd_next = wd_reg + 16'd1;
      default: wd_next = wd_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
      wd_reg    <= '0;
    end else begin
      timer_reg <= timer_next;
      wd_reg    <= wd_next;
    end
  end

  // Channel, round counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_reg      <= '0;
      round_reg   <= '0;
      avg_vld_reg <= 1'b0;
      tmo_err_reg <= 1'b0;
    end else begin
      avg_vld_reg <= publish;
      if (timeout) begin
        tmo_err_reg <= 1'b1;
        ch_reg      <= '0;
        round_reg   <= '0;
      end else if (capt) begin
        ch_reg <= (ch_reg == 2'd2) ? 2'd0 : ch_reg + 2'd1;
        if (ch_reg == 2'd2) begin
          round_reg <= round_last ? '0 : round_reg + RND_W'(1);
        end
      end else if ((state_reg == HALT) && clr_err) begin
        tmo_err_reg <= 1'b0;
      end
    end
  end

  // Per-channel accumulator and published average. The sum includes the
  // sample being captured so the final CAPT of a window lands in the average.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_sum;
    logic [11:0]      avg_reg;

    assign acc_sum = acc_reg + ((ch_reg == 2'(gi)) ? ACC_W'(sample) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg <= '0;
        avg_reg <= '0;
      end else begin
        if (acc_clr) begin
          acc_reg <= '0;
        end else if (capt) begin
          acc_reg <= acc_sum;
        end
        if (publish) begin
          avg_reg <= acc_sum[ACC_W-1:AVG_LOG2];
        end
      end
    end
  end

  assign lft_avg  = g_ch[0].avg_reg;
  assign batt_avg = g_ch[1].avg_reg;
  assign rght_avg = g_ch[2].avg_reg;
  assign avg_vld  = avg_vld_reg;
  assign ch       = ch_reg;
  assign tmo_err  = tmo_err_reg;

endmodule

// File: doc/a2d_sched.md
# a2d_sched

Conversion scheduler for the 3-channel A2D interface (left load cell, battery, right load cell). It issues one-cycle `nxt` requests at a fixed period and tracks which channel each request converts, mirroring the interface's left→batt→right round robin. After each completed conversion it captures the result, accumulates 2^AVG_LOG2 full rounds per channel, and publishes averaged readings with a valid strobe. A watchdog halts scheduling if a conversion never completes.

## Interface
- PERIOD, 4096: minimum cycles between consecutive `nxt` pulses (≥ 8).
- TMO, 1024: max cycles from `nxt` to `cnv_done` before a timeout.
- AVG_LOG2, 2: log2 of rounds averaged (0..4).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scheduling enable (level).
- clr_err  in  1  pulse; clears `tmo_err` and leaves HALT.
- nxt  out  1  one-cycle conversion request to the A2D interface.
- cnv_done  in  1  one-cycle pulse from the A2D interface; the channel result register updates on the following edge.
- lft_ld, batt, rght_ld  in  12 each  A2D interface result registers.
- lft_avg, batt_avg, rght_avg  out  12 each  averaged results.
- avg_vld  out  1  one-cycle pulse when the averages update.
- ch  out  2  channel of the outstanding or next conversion: 0 = left, 1 = batt, 2 = right.
- tmo_err  out  1  sticky timeout flag.

## Operation
- States:
  - IDLE→WAIT when `en`=1.
  - WAIT→REQ when period timer ≥ PERIOD-1; WAIT→IDLE when `en`=0.
  - REQ (`nxt`=1, timer cleared)→BUSY.
  - BUSY→CAPT on `cnv_done`; BUSY→HALT on timeout.
  - CAPT→WAIT.
  - HALT→IDLE on `clr_err`.
- Period timer: 16-bit, free-runs from 0 after each REQ; saturates; it does not count in IDLE or HALT.
- CAPT: read the input selected by `ch` and add it to that channel's accumulator (width 12+AVG_LOG2, no overflow possible).
- Channel advance:
  - `ch` advances in CAPT: 0→1→2→0.
  - On 2→0, increment the round counter (AVG_LOG2 bits).
  - When the round counter wraps, load each average as accumulator >> AVG_LOG2 (truncating), clear all accumulators, and pulse `avg_vld`.
  - AVG_LOG2=0: every round publishes.
- Watchdog: cycle counter cleared in REQ, counts in BUSY. Reaching TMO without `cnv_done`:
  - set `tmo_err`;
  - clear accumulators and round counter;
  - set `ch`=0;
  - enter HALT.
  - Averages hold their last published values.
- Simultaneous `cnv_done` and timeout: `cnv_done` wins.
- `cnv_done` outside BUSY: ignored.
- `en` deasserted in REQ/BUSY/CAPT: the current conversion completes and is captured; return to IDLE from WAIT. Accumulators are kept, so a resumed round continues on the correct channel.
- `clr_err` outside HALT: no effect. Channel resync after timeout is the system's responsibility (the A2D interface must also be reset).

## Timing
- Reset values: `nxt`=0, `avg_vld`=0, `tmo_err`=0, `ch`=0, all averages 0x000, accumulators 0, state IDLE.
- First `nxt` occurs PERIOD cycles after `en` rises (timer starts at 0 on entering WAIT).
- `nxt`-to-`nxt` spacing = max(PERIOD, conversion latency + 3) cycles.
- Capture point: `cnv_done` at cycle t; the input is sampled in CAPT at cycle t+1, when the result register already holds the new value.
- `avg_vld` rises the cycle after the final CAPT of the last round. Averages are valid in that same cycle and held until the next publish.
- `tmo_err` asserts the cycle after the watchdog reaches TMO, and stays set until `clr_err` or reset.
- Reset mid-operation: immediate return to reset values; no `nxt` glitch.

## Test plan
- **Steady conversion:** PERIOD=64, `en`=1, model returns `cnv_done` 20 cycles after `nxt`, inputs constant L=0x400, B=0x9C0, R=0x3FF.
  - `nxt` every 64 cycles.
  - `ch` sequence 0,1,2,0…
  - After 12 conversions: `avg_vld` pulse, averages 0x400/0x9C0/0x3FF.
- **Averaging truncation:** AVG_LOG2=2, left values 1,2,3,5 over four rounds.
  - `lft_avg`=2 (11>>2).
  - Accumulators cleared; the next window is independent.
- **Slow conversion:** PERIOD=16, `cnv_done` 40 cycles after `nxt`.
  - The next `nxt` follows CAPT by one WAIT cycle.
  - No timeout with TMO=64.
- **Timeout:** TMO=32, withhold `cnv_done` after the second `nxt`.
  - `tmo_err`=1 at cycle 33 after `nxt`; `ch`=0; no further `nxt`.
  - Averages unchanged.
  - `clr_err` → IDLE → scheduling resumes with `ch`=0.
- **Race:** `cnv_done` on the exact timeout cycle → capture proceeds, `tmo_err` stays 0.
- **Enable and reset:**
  - Drop `en` during BUSY: the capture still occurs, then no `nxt` until `en` returns, and `ch` continues from its held value.
  - Assert `rst_n`=0 mid-BUSY: all outputs return to reset values.
